multicycle_cpu: RTL

MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

---
 rtl/multicycle_cpu.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_cpu.sv
// Multicycle load/store CPU: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer driving a
// registered request/acknowledge memory port shared by fetch and data accesses.
module multicycle_cpu #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned REG_AW = 2
) (
    input  logic              Clock,
    input  logic              Reset_n,
    output logic              MemReq,
    output logic              MemWe,
    output logic [DATA_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData,
    input  logic              MemAck,
    output logic              Halted,
    output logic [DATA_W-1:0] Pc,
    output logic [31:0]       Retired
);
    localparam int unsigned NREG  = 1 << REG_AW;
    localparam int unsigned IMM_W = DATA_W - 4 - 2 * REG_AW;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
    typedef enum logic [3:0] {
        OP_R    = 4'd0,
        OP_ADDI = 4'd1,
        OP_LW   = 4'd2,
        OP_SW   = 4'd3,
        OP_BEQ  = 4'd4,
        OP_BNE  = 4'd5,
        OP_JMP  = 4'd6,
        OP_HALT = 4'd15
    } op_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] ir, a, b, alu;
    logic [DATA_W-1:0] ir_n, a_n, b_n, alu_n, pc_n;
    logic [DATA_W-1:0] regs [NREG];
    logic [3:0]        opcode, func;
    logic [REG_AW-1:0] rs, rt, rd, wr_idx;
    logic [DATA_W-1:0] imm, jtarget, rs_val, rt_val, r_result;
    logic              mem_done, retire, wr_en, is_sw;

    assign opcode   = ir[DATA_W-1 -: 4];
    assign rs       = ir[DATA_W-5 -: REG_AW];
    assign rt       = ir[DATA_W-5-REG_AW -: REG_AW];
    assign rd       = ir[DATA_W-5-2*REG_AW -: REG_AW];
    assign func     = ir[3:0];
    assign imm      = {{(DATA_W-IMM_W){ir[IMM_W-1]}}, ir[IMM_W-1:0]};
    assign jtarget  = {4'b0000, ir[DATA_W-5:0]};
    assign rs_val   = (rs == '0) ? '0 : regs[rs];
    assign rt_val   = (rt == '0) ? '0 : regs[rt];
    assign mem_done = MemReq && MemAck;
    assign is_sw    = (opcode == OP_SW);
    assign Halted   = (state == HALT);

    always_comb begin
        r_result = '0;
        case (func)
            4'd0:    r_result = a + b;
            4'd1:    r_result = a - b;
            4'd2:    r_result = a & b;
            4'd3:    r_result = a | b;
            4'd4:    r_result = a ^ b;
            4'd5:    r_result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd6:    r_result = a << b[3:0];
            4'd7:    r_result = a >> b[3:0];
            default: r_result = '0;
        endcase
    end

    always_comb begin
        state_n = state;
        pc_n    = Pc;
        ir_n    = ir;
        a_n     = a;
        b_n     = b;
        alu_n   = alu;
        retire  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = rd;
        unique case (state)
            FETCH: begin
                if (mem_done) begin
                    ir_n    = MemRData;
                    pc_n    = Pc + DATA_W'(1);
                    state_n = DECODE;
                end
            end
            DECODE: begin
                a_n     = rs_val;
                b_n     = rt_val;
                state_n = EXEC;
            end
            EXEC: begin
                state_n = FETCH;
                case (opcode)
                    OP_R: begin
                        alu_n   = r_result;
                        state_n = WB;
                    end
                    OP_ADDI: begin
                        alu_n   = a + imm;
                        state_n = WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_n   = a + imm;
                        state_n = MEM;
                    end
                    OP_BEQ: begin
                        if (a == b) pc_n = Pc + imm;
                        retire = 1'b1;
                    end
                    OP_BNE: begin
                        if (a != b) pc_n = Pc + imm;
                        retire = 1'b1;
                    end
                    OP_JMP: begin
                        pc_n   = jtarget;
                        retire = 1'b1;
                    end
                    OP_HALT: state_n = HALT;
                    default: retire = 1'b1;
                endcase
            end
            MEM: begin
                if (mem_done) begin
                    if (is_sw) begin
                        state_n = FETCH;
                        retire  = 1'b1;
                    end else begin
                        alu_n   = MemRData;
                        state_n = WB;
                    end
                end
            end
            WB: begin
                wr_en   = 1'b1;
                wr_idx  = (opcode == OP_R) ? rd : rt;
                state_n = FETCH;
                retire  = 1'b1;
            end
            HALT: state_n = HALT;
            default: state_n = FETCH;
        endcase
    end

    // Memory port is registered from the next state, so the first fetch after
    // reset sees one idle cycle while the request is being raised.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state    <= FETCH;
            Pc       <= '0;
            ir       <= '0;
            a        <= '0;
            b        <= '0;
            alu      <= '0;
            Retired  <= '0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            state    <= state_n;
            Pc       <= pc_n;
            ir       <= ir_n;
            a        <= a_n;
            b        <= b_n;
            alu      <= alu_n;
            if (retire) Retired <= Retired + 32'd1;
            if (wr_en && (wr_idx != '0)) regs[wr_idx] <= alu;
            MemReq   <= (state_n == FETCH) || (state_n == MEM);
            MemWe    <= (state_n == MEM) && is_sw;
            MemAddr  <= (state_n == MEM) ? alu_n : pc_n;
            MemWData <= ((state_n == MEM) && is_sw) ? b : '0;
        end
    end
endmodule
